// File: rtl/jump_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jump_scheduler
//  Purpose  : Per-frame vertical-motion sequencer for the doodle. Steps the
//             rise / fall / bounce / death sequence once per frame tick and
//             emits the doodle screen Y plus the per-frame world scroll.
//  Revision : 1.0  initial release
// ============================================================================
module jump_scheduler #(
  parameter int START_Y       = 400,
  parameter int JUMP_V        = 12,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 10,
  parameter int SCROLL_LINE   = 200,
  parameter int EARTH         = 480,
  parameter int DOODLE_HEIGHT = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [1:0] game_state,
  input  logic       platform_hit,
  output logic [9:0] doodle_y,
  output logic [9:0] scroll_dy,
  output logic       scroll_valid,
  output logic       jump_pulse,
  output logic       falling,
  output logic       dead
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd2,
    S_DEAD = 2'd3
  } state_e;

  localparam logic [1:0]         C_GS_WAIT    = 2'd0;
  localparam logic [1:0]         C_GS_PLAY    = 2'd1;
  localparam logic [1:0]         C_GS_OVER    = 2'd2;
  localparam logic [9:0]         C_START_Y    = 10'(START_Y);
  localparam logic [4:0]         C_JUMP_V     = 5'(JUMP_V);
  localparam logic [4:0]         C_GRAVITY    = 5'(GRAVITY);
  localparam logic [4:0]         C_MAX_FALL   = 5'(MAX_FALL);
  localparam logic signed [10:0] C_SCROLL_S   = 11'(SCROLL_LINE);
  localparam logic [9:0]         C_SCROLL_Y   = 10'(SCROLL_LINE);
  // Lowest top-edge Y: the sprite bottom sits exactly on the screen bottom.
  localparam logic signed [10:0] C_GROUND_S   = 11'(EARTH - DOODLE_HEIGHT);
  localparam logic [9:0]         C_GROUND_Y   = 10'(EARTH - DOODLE_HEIGHT);

  state_e      state_q, state_d;
  logic [9:0]  y_q, y_d;
  logic [4:0]  vel_q, vel_d;
  logic [9:0]  sdy_q, sdy_d;
  logic        sv_q, sv_d;
  logic        jp_q, jp_d;

  // Position math is carried in 11-bit signed so nothing wraps below zero.
  logic signed [10:0] w_y_s;
  logic signed [10:0] w_rise_y;
  logic signed [10:0] w_fall_y;
  logic signed [5:0]  w_vel_rise;
  logic [5:0]         w_vel_sum;
  logic [4:0]         w_vel_fall;

  assign w_y_s      = signed'({1'b0, y_q});
  assign w_rise_y   = w_y_s - signed'({6'b0, vel_q});
  assign w_vel_rise = signed'({1'b0, vel_q}) - signed'({1'b0, C_GRAVITY});
  assign w_vel_sum  = {1'b0, vel_q} + {1'b0, C_GRAVITY};
  assign w_vel_fall = (w_vel_sum > {1'b0, C_MAX_FALL}) ? C_MAX_FALL : w_vel_sum[4:0];
  assign w_fall_y   = w_y_s + signed'({6'b0, w_vel_fall});

  // State and datapath registers; reset returns everything to the WAIT pose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      y_q     <= C_START_Y;
      vel_q   <= 5'd0;
      sdy_q   <= 10'd0;
      sv_q    <= 1'b0;
      jp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      sdy_q   <= sdy_d;
      sv_q    <= sv_d;
      jp_q    <= jp_d;
    end
  end

  // Next state: game_state overrides are checked every cycle, motion only on tick.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    sdy_d   = sdy_q;
    sv_d    = 1'b0;
    jp_d    = 1'b0;

    if (game_state == C_GS_WAIT) begin
      state_d = S_WAIT;
      y_d     = C_START_Y;
      vel_d   = 5'd0;
      sdy_d   = 10'd0;
    end else if (game_state == C_GS_OVER &&
                 (state_q == S_RISE || state_q == S_FALL)) begin
      state_d = S_DEAD;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          y_d = C_START_Y;
          if (game_state == C_GS_PLAY) begin
            state_d = S_RISE;
            vel_d   = C_JUMP_V;
          end
        end
        S_RISE: begin
          if (frame_tick) begin
            // Motion above the scroll line is converted into world scroll.
            if (w_rise_y < C_SCROLL_S) begin
              y_d   = C_SCROLL_Y;
              sdy_d = 10'(C_SCROLL_S - w_rise_y);
            end else begin
              y_d   = w_rise_y[9:0];
              sdy_d = 10'd0;
            end
            sv_d = 1'b1;
            if (w_vel_rise <= 6'sd0) begin
              vel_d   = 5'd0;
              state_d = S_FALL;
            end else begin
              vel_d = w_vel_rise[4:0];
            end
          end
        end
        S_FALL: begin
          if (frame_tick) begin
            // A platform hit wins over reaching the ground on the same tick.
            if (platform_hit) begin
              vel_d   = C_JUMP_V;
              state_d = S_RISE;
              jp_d    = 1'b1;
            end else begin
              vel_d = w_vel_fall;
              if (w_fall_y >= C_GROUND_S) begin
                y_d     = C_GROUND_Y;
                state_d = S_DEAD;
              end else begin
                y_d = w_fall_y[9:0];
              end
            end
          end
        end
        S_DEAD: begin
          state_d = S_DEAD;
        end
        default: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  assign doodle_y     = y_q;
  assign scroll_dy    = sdy_q;
  assign scroll_valid = sv_q;
  assign jump_pulse   = jp_q;
  assign falling      = (state_q == S_FALL);
  assign dead         = (state_q == S_DEAD);

endmodule
`default_nettype wire

// File: tb/tb_jump_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_jump_scheduler
//  Purpose  : Self-checking bench for jump_scheduler. Two instances (default
//             START_Y and START_Y=210) share stimulus and are compared against
//             a frame-level reference model of the doodle's motion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jump_scheduler;

  localparam int JUMP_V        = 12;
  localparam int GRAVITY       = 1;
  localparam int MAX_FALL      = 10;
  localparam int SCROLL_LINE   = 200;
  localparam int EARTH         = 480;
  localparam int DOODLE_HEIGHT = 60;
  localparam int START_A       = 400;
  localparam int START_B       = 210;

  localparam int M_WAIT = 0;
  localparam int M_RISE = 1;
  localparam int M_FALL = 2;
  localparam int M_DEAD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       platform_hit = 1'b0;
  logic [1:0] game_state = 2'd0;

  logic [9:0] a_y, a_sdy, b_y, b_sdy;
  logic       a_sv, a_jp, a_fall, a_dead;
  logic       b_sv, b_jp, b_fall, b_dead;

  always #5 clk = ~clk;

  jump_scheduler u_dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_state(game_state),
    .platform_hit(platform_hit), .doodle_y(a_y), .scroll_dy(a_sdy),
    .scroll_valid(a_sv), .jump_pulse(a_jp), .falling(a_fall), .dead(a_dead)
  );

  jump_scheduler #(.START_Y(START_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_state(game_state),
    .platform_hit(platform_hit), .doodle_y(b_y), .scroll_dy(b_sdy),
    .scroll_valid(b_sv), .jump_pulse(b_jp), .falling(b_fall), .dead(b_dead)
  );

  typedef struct {
    int st;
    int y;
    int v;
    int sdy;
    int sv;
    int jp;
  } mdl_t;

  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic mdl_t mdl_reset(input int sy);
    mdl_t m;
    m.st = M_WAIT; m.y = sy; m.v = 0; m.sdy = 0; m.sv = 0; m.jp = 0;
    return m;
  endfunction

  // One clock of the game rules, written in plain integer arithmetic.
  function automatic mdl_t mdl_next(input mdl_t m, input int gs, input bit tk,
                                    input bit hit, input int sy);
    mdl_t n;
    int   ny;
    n = m; n.sv = 0; n.jp = 0;
    if (gs == 0) return mdl_reset(sy);
    if (gs == 2 && (m.st == M_RISE || m.st == M_FALL)) begin
      n.st = M_DEAD;
      return n;
    end
    case (m.st)
      M_WAIT: if (gs == 1) begin n.st = M_RISE; n.v = JUMP_V; end
      M_RISE: if (tk) begin
        ny = m.y - m.v;
        if (ny < SCROLL_LINE) begin n.y = SCROLL_LINE; n.sdy = SCROLL_LINE - ny; end
        else begin n.y = ny; n.sdy = 0; end
        n.sv = 1;
        n.v  = m.v - GRAVITY;
        if (n.v <= 0) begin n.v = 0; n.st = M_FALL; end
      end
      M_FALL: if (tk) begin
        if (hit) begin n.v = JUMP_V; n.st = M_RISE; n.jp = 1; end
        else begin
          n.v = (m.v + GRAVITY > MAX_FALL) ? MAX_FALL : m.v + GRAVITY;
          n.y = m.y + n.v;
          if (n.y + DOODLE_HEIGHT >= EARTH) begin
            n.y  = EARTH - DOODLE_HEIGHT;
            n.st = M_DEAD;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic check_eq(input string tag, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, expv, $time);
    end
  endtask

  task automatic check_all();
    check_eq("a_y",    a_y,    ma.y);
    check_eq("a_sdy",  a_sdy,  ma.sdy);
    check_eq("a_sv",   a_sv,   ma.sv);
    check_eq("a_jp",   a_jp,   ma.jp);
    check_eq("a_fall", a_fall, int'(ma.st == M_FALL));
    check_eq("a_dead", a_dead, int'(ma.st == M_DEAD));
    check_eq("b_y",    b_y,    mb.y);
    check_eq("b_sdy",  b_sdy,  mb.sdy);
    check_eq("b_sv",   b_sv,   mb.sv);
    check_eq("b_jp",   b_jp,   mb.jp);
    check_eq("b_fall", b_fall, int'(mb.st == M_FALL));
    check_eq("b_dead", b_dead, int'(mb.st == M_DEAD));
  endtask

  // Drive one cycle, advance the model on the same edge, check 1 ns later.
  task automatic step(input bit tk, input bit hit);
    frame_tick   = tk;
    platform_hit = hit;
    @(posedge clk);
    if (rst_n) begin
      ma = mdl_next(ma, int'(game_state), tk, hit, START_A);
      mb = mdl_next(mb, int'(game_state), tk, hit, START_B);
    end
    #1;
    frame_tick   = 1'b0;
    platform_hit = 1'b0;
    check_all();
  endtask

  // Assert reset away from the clock edge and confirm it acts immediately.
  task automatic mid_cycle_reset();
    #2;
    rst_n = 1'b0;
    ma = mdl_reset(START_A);
    mb = mdl_reset(START_B);
    #1;
    check_eq("arst_y",    a_y,    START_A);
    check_eq("arst_sdy",  a_sdy,  0);
    check_eq("arst_fall", a_fall, 0);
    check_eq("arst_dead", a_dead, 0);
    check_all();
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  int exp_rise [12] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322};
  int y_before;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ma = mdl_reset(START_A);
    mb = mdl_reset(START_B);

    // Reset state
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("rst_y_a",   a_y,   START_A);
    check_eq("rst_y_b",   b_y,   START_B);
    check_eq("rst_sdy",   a_sdy, 0);
    check_eq("rst_dead",  a_dead, 0);
    rst_n = 1'b1;

    // Start the game and rise through 12 ticks
    game_state = 2'd1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      check_eq("rise_y",   a_y,   exp_rise[i]);
      check_eq("rise_sdy", a_sdy, 0);
      check_eq("rise_sv",  a_sv,  1);
      if (i == 0) begin
        check_eq("scr_y0",   b_y,   200);
        check_eq("scr_dy0",  b_sdy, 2);
      end
      if (i == 1) begin
        check_eq("scr_y1",   b_y,   200);
        check_eq("scr_dy1",  b_sdy, 11);
      end
      step(1'b0, 1'b0);
      check_eq("sv_pulse", a_sv, 0);
    end
    check_eq("rise_done_fall", a_fall, 1);

    // Free fall to the ground
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 1'b0);
      if (i == 10) check_eq("fall10_y", a_y, 377);
      if (i == 14) check_eq("fall14_y", a_y, 417);
      if (i == 15) begin
        check_eq("fall15_y",    a_y,    420);
        check_eq("fall15_dead", a_dead, 1);
      end
    end
    repeat (3) step(1'b1, 1'b1);
    check_eq("dead_hold_y", a_y,    420);
    check_eq("dead_hold_d", a_dead, 1);

    // Game over then back to waiting
    game_state = 2'd2;
    repeat (2) step(1'b1, 1'b0);
    check_eq("over_b_dead", b_dead, 1);
    game_state = 2'd0;
    step(1'b0, 1'b0);
    check_eq("wait_y",    a_y,    400);
    check_eq("wait_dead", a_dead, 0);

    // Fall down to 350 and bounce
    game_state = 2'd1;
    step(1'b0, 1'b0);
    repeat (12) step(1'b1, 1'b0);
    repeat (7) step(1'b1, 1'b0);
    check_eq("pre_hit_y", a_y, 350);
    step(1'b1, 1'b1);
    check_eq("hit_jp", a_jp, 1);
    check_eq("hit_y",  a_y,  350);
    step(1'b0, 1'b0);
    check_eq("hit_jp_end", a_jp, 0);
    step(1'b1, 1'b0);
    check_eq("bounce_y", a_y, 338);

    // Bounce on the same tick that would reach the ground
    for (int k = 0; k < 40 && ma.st != M_FALL; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 60 && ma.st == M_FALL &&
         ma.y + ((ma.v + GRAVITY > MAX_FALL) ? MAX_FALL : ma.v + GRAVITY)
              + DOODLE_HEIGHT < EARTH; k++)
      step(1'b1, 1'b0);
    check_eq("edge_fall", a_fall, 1);
    y_before = ma.y;
    step(1'b1, 1'b1);
    check_eq("edge_dead", a_dead, 0);
    check_eq("edge_jp",   a_jp,   1);
    check_eq("edge_y",    a_y,    y_before);

    // Asynchronous reset mid-rise, then the first tick after release
    step(1'b1, 1'b0);
    mid_cycle_reset();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("post_rst_y", a_y, 388);

    // Randomised play
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      game_state = (r < 2) ? 2'd0 : ((r < 4) ? 2'd2 : 2'd1);
      if ($urandom_range(0, 299) == 0) begin
        mid_cycle_reset();
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
